spi_ram_ctrl: RTL

Command-decoding RAM controller directly downstream of the SPI slave interface. It takes each 10-bit frame (2-bit opcode plus 8-bit payload) delivered on rx_data/rx_valid and executes it against an internal single-port RAM: set write address, write data, set read address, or read data. Read results are returned on dout/tx_valid, which the SPI slave shifts out on MISO.

---
 rtl/spi_ram_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - command-decoding RAM controller behind the SPI slave
//
// Decodes 10-bit frames {opcode[1:0], payload[7:0]} from the SPI slave and
// executes them against an internal single-port RAM. Read data is returned
// on dout with a one-cycle tx_valid strobe.
//
// Ports:
//   clk       in   1   clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   din       in   10  frame: din[9:8] opcode, din[7:0] payload
//   rx_valid  in   1   frame valid level; only its rising edge is a command
//   dout      out  8   read data, held between reads
//   tx_valid  out  1   one-cycle strobe: dout carries new read data
//   cmd_err   out  1   one-cycle strobe: illegal or dropped command
//
// Opcodes: 00 SET_WA, 01 WRITE, 10 SET_RA, 11 READ.

module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int AUTO_INC  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       cmd_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] OP_SET_WA = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SET_RA = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    // One extra bit so MEM_DEPTH == 2**ADDR_SIZE is representable.
    localparam logic [ADDR_SIZE:0] DEPTH_W = (ADDR_SIZE + 1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE:0] LAST_W  = (ADDR_SIZE + 1)'(MEM_DEPTH - 1);

    logic [7:0]           mem [MEM_DEPTH];

    logic [1:0]           state_q,    state_d;
    logic                 rx_prev_q,  rx_prev_d;
    logic [ADDR_SIZE-1:0] wr_addr_q,  wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q,  rd_addr_d;
    logic                 wa_set_q,   wa_set_d;
    logic                 ra_set_q,   ra_set_d;
    logic [7:0]           dout_q,     dout_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 cmd_err_q,  cmd_err_d;

    logic                 rx_rise;
    logic [1:0]           opcode;
    logic [ADDR_SIZE-1:0] payload_addr;
    logic                 mem_we;
    logic [7:0]           mem_rdata;

    function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
        return ({1'b0, a} < DEPTH_W);
    endfunction

    // Wraps at MEM_DEPTH-1; an out-of-range address just counts up modulo
    // the address width.
    function automatic logic [ADDR_SIZE-1:0] addr_inc(input logic [ADDR_SIZE-1:0] a);
        if ({1'b0, a} == LAST_W) begin
            return '0;
        end
        return a + ADDR_SIZE'(1);
    endfunction

    assign rx_rise      = rx_valid & ~rx_prev_q;
    assign opcode       = din[9:8];
    assign payload_addr = din[ADDR_SIZE-1:0];
    assign mem_rdata    = mem[rd_addr_q];

    always_comb begin
        state_d    = state_q;
        rx_prev_d  = rx_valid;   // tracks every cycle so dropped frames never replay
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        wa_set_d   = wa_set_q;
        ra_set_d   = ra_set_q;
        dout_d     = dout_q;
        tx_valid_d = 1'b0;
        cmd_err_d  = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_rise) begin
                    case (opcode)
                        OP_SET_WA: begin
                            wr_addr_d = payload_addr;
                            wa_set_d  = 1'b1;
                        end
                        OP_WRITE: begin
                            if (!wa_set_q || !in_range(wr_addr_q)) begin
                                cmd_err_d = 1'b1;
                            end else begin
                                mem_we = 1'b1;
                                if (AUTO_INC != 0) begin
                                    wr_addr_d = addr_inc(wr_addr_q);
                                end
                            end
                        end
                        OP_SET_RA: begin
                            rd_addr_d = payload_addr;
                            ra_set_d  = 1'b1;
                        end
                        default: begin
                            if (!ra_set_q) begin
                                cmd_err_d = 1'b1;
                            end else begin
                                state_d = ST_READ;
                            end
                        end
                    endcase
                end
            end
            ST_READ: begin
                // Out-of-range reads still respond, with zero data and an error.
                if (in_range(rd_addr_q)) begin
                    dout_d = mem_rdata;
                end else begin
                    dout_d    = 8'h00;
                    cmd_err_d = 1'b1;
                end
                tx_valid_d = 1'b1;
                state_d    = ST_RESP;
                if (rx_rise) begin
                    cmd_err_d = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (AUTO_INC != 0) begin
                    rd_addr_d = addr_inc(rd_addr_q);
                end
                if (rx_rise) begin
                    cmd_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rx_prev_q  <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            wa_set_q   <= 1'b0;
            ra_set_q   <= 1'b0;
            dout_q     <= 8'h00;
            tx_valid_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_prev_q  <= rx_prev_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            wa_set_q   <= wa_set_d;
            ra_set_q   <= ra_set_d;
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr_q] <= din[7:0];
        end
    end

    assign dout     = dout_q;
    assign tx_valid = tx_valid_q;
    assign cmd_err  = cmd_err_q;

endmodule
